// File: rtl/wb_ibus_dbus_arbiter_if.sv
// Bus bundle between the IBUS/DBUS masters, the arbiter and the shared slave.
// The arbiter uses the slave modport; the environment side uses master.
interface wb_ibus_dbus_arbiter_if;
    logic [31:0] i_adr_i;
    logic        i_cyc_i;
    logic        i_stb_i;
    logic [31:0] i_dat_o;
    logic        i_ack_o;
    logic        i_err_o;
    logic [31:0] d_adr_i;
    logic [31:0] d_dat_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic        d_cyc_i;
    logic        d_stb_i;
    logic [31:0] d_dat_o;
    logic        d_ack_o;
    logic        d_err_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    modport slave (
        input  i_adr_i, i_cyc_i, i_stb_i,
        output i_dat_o, i_ack_o, i_err_o,
        input  d_adr_i, d_dat_i, d_we_i, d_sel_i, d_cyc_i, d_stb_i,
        output d_dat_o, d_ack_o, d_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_dat_i, s_ack_i,
        output gnt_o, timeout_o
    );

    modport master (
        output i_adr_i, i_cyc_i, i_stb_i,
        input  i_dat_o, i_ack_o, i_err_o,
        output d_adr_i, d_dat_i, d_we_i, d_sel_i, d_cyc_i, d_stb_i,
        input  d_dat_o, d_ack_o, d_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i,
        input  gnt_o, timeout_o
    );
endinterface

// File: rtl/wb_ibus_dbus_arbiter.sv
// Round-robin Wishbone classic arbiter: IBUS + DBUS onto one slave port,
// with an idle turnaround cycle and an ack timeout that returns a bus error.
module wb_ibus_dbus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    wb_ibus_dbus_arbiter_if.slave     bus
);
    localparam int unsigned CW =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;

    logic        req_i, req_d, expire;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_dat;
    logic        i_ack, i_err, d_ack, d_err;

    assign req_i = bus.i_cyc_i & bus.i_stb_i;
    assign req_d = bus.d_cyc_i & bus.d_stb_i;

    // Ack on the expiry cycle wins over the timeout.
    assign expire = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) &&
                    (wait_cnt_q == TMAX) && !bus.s_ack_i;

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q | expire;
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_sel      = 4'b0000;
        s_adr      = 32'h0;
        s_dat      = 32'h0;
        i_ack      = 1'b0;
        i_err      = 1'b0;
        d_ack      = 1'b0;
        d_err      = 1'b0;
        unique case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (req_i && (!req_d || last_d_q)) begin
                    state_d  = GNT_I;
                    last_d_d = 1'b0;
                end else if (req_d) begin
                    state_d  = GNT_D;
                    last_d_d = 1'b1;
                end
            end
            GNT_I: begin
                s_cyc      = bus.i_cyc_i;
                s_stb      = bus.i_stb_i;
                s_adr      = bus.i_adr_i;
                s_sel      = 4'b1111;
                i_ack      = bus.s_ack_i;
                i_err      = expire;
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (bus.s_ack_i || !bus.i_cyc_i || expire)
                    state_d = IDLE;
            end
            GNT_D: begin
                s_cyc      = bus.d_cyc_i;
                s_stb      = bus.d_stb_i;
                s_we       = bus.d_we_i;
                s_sel      = bus.d_sel_i;
                s_adr      = bus.d_adr_i;
                s_dat      = bus.d_dat_i;
                d_ack      = bus.s_ack_i;
                d_err      = expire;
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (bus.s_ack_i || !bus.d_cyc_i || expire)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b1;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.s_cyc_o   = s_cyc;
    assign bus.s_stb_o   = s_stb;
    assign bus.s_we_o    = s_we;
    assign bus.s_sel_o   = s_sel;
    assign bus.s_adr_o   = s_adr;
    assign bus.s_dat_o   = s_dat;
    assign bus.i_dat_o   = bus.s_dat_i;
    assign bus.d_dat_o   = bus.s_dat_i;
    assign bus.i_ack_o   = i_ack;
    assign bus.i_err_o   = i_err;
    assign bus.d_ack_o   = d_ack;
    assign bus.d_err_o   = d_err;
    assign bus.gnt_o     = state_q;
    assign bus.timeout_o = timeout_q;
endmodule

// File: tb/tb_wb_ibus_dbus_arbiter.sv
// Directed bench for wb_ibus_dbus_arbiter with a 4-cycle ack timeout.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_wb_ibus_dbus_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    wb_ibus_dbus_arbiter_if bus ();

    wb_ibus_dbus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_adr_i = 32'h0;
        bus.i_cyc_i = 1'b0;
        bus.i_stb_i = 1'b0;
        bus.d_adr_i = 32'h0;
        bus.d_dat_i = 32'h0;
        bus.d_we_i  = 1'b0;
        bus.d_sel_i = 4'h0;
        bus.d_cyc_i = 1'b0;
        bus.d_stb_i = 1'b0;
        bus.s_dat_i = 32'h0;
        bus.s_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic d_req(input logic on);
        bus.d_adr_i = 32'h0000_0200;
        bus.d_dat_i = 32'h1234_5678;
        bus.d_we_i  = 1'b1;
        bus.d_sel_i = 4'b0011;
        bus.d_cyc_i = on;
        bus.d_stb_i = on;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        do_reset();
        step();
        #1;
        chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
        chk("rst_cyc", 32'(bus.s_cyc_o), 32'h0);
        chk("rst_to", 32'(bus.timeout_o), 32'h0);
        chk("rst_sel", 32'(bus.s_sel_o), 32'h0);

        // Single IBUS read, slave acks in the second grant cycle
        bus.i_adr_i = 32'h0000_0100;
        bus.i_cyc_i = 1'b1;
        bus.i_stb_i = 1'b1;
        #1;
        chk("t1_gnt0", 32'(bus.gnt_o), 32'h0);
        chk("t1_stb0", 32'(bus.s_stb_o), 32'h0);
        step();
        #1;
        chk("t1_gnt1", 32'(bus.gnt_o), 32'h1);
        chk("t1_stb1", 32'(bus.s_stb_o), 32'h1);
        chk("t1_adr", bus.s_adr_o, 32'h0000_0100);
        chk("t1_we", 32'(bus.s_we_o), 32'h0);
        chk("t1_sel", 32'(bus.s_sel_o), 32'hF);
        chk("t1_noack", 32'(bus.i_ack_o), 32'h0);
        step();
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'hDEAD_BEEF;
        #1;
        chk("t1_ack", 32'(bus.i_ack_o), 32'h1);
        chk("t1_dat", bus.i_dat_o, 32'hDEAD_BEEF);
        chk("t1_dack", 32'(bus.d_ack_o), 32'h0);
        step();
        bus.s_ack_i = 1'b0;
        bus.i_cyc_i = 1'b0;
        bus.i_stb_i = 1'b0;
        #1;
        chk("t1_gnt2", 32'(bus.gnt_o), 32'h0);
        chk("t1_ack2", 32'(bus.i_ack_o), 32'h0);

        // Simultaneous requests right after reset alternate I, D, I
        do_reset();
        bus.i_adr_i = 32'h0000_0100;
        bus.i_cyc_i = 1'b1;
        bus.i_stb_i = 1'b1;
        d_req(1'b1);
        step();
        bus.s_ack_i = 1'b1;
        #1;
        chk("t2_g1", 32'(bus.gnt_o), 32'h1);
        chk("t2_iack", 32'(bus.i_ack_o), 32'h1);
        step();
        bus.s_ack_i = 1'b0;
        #1;
        chk("t2_idle", 32'(bus.gnt_o), 32'h0);
        step();
        bus.s_ack_i = 1'b1;
        #1;
        chk("t2_g2", 32'(bus.gnt_o), 32'h2);
        chk("t2_we", 32'(bus.s_we_o), 32'h1);
        chk("t2_sel", 32'(bus.s_sel_o), 32'h3);
        chk("t2_dat", bus.s_dat_o, 32'h1234_5678);
        chk("t2_adr", bus.s_adr_o, 32'h0000_0200);
        chk("t2_dack", 32'(bus.d_ack_o), 32'h1);
        chk("t2_iack0", 32'(bus.i_ack_o), 32'h0);
        step();
        bus.s_ack_i = 1'b0;
        step();
        bus.s_ack_i = 1'b1;
        #1;
        chk("t2_g3", 32'(bus.gnt_o), 32'h1);
        step();
        idle_inputs();

        // Ack lands exactly on the expiry cycle: ack wins
        do_reset();
        d_req(1'b1);
        step();
        #1;
        chk("t4_g1err", 32'(bus.d_err_o), 32'h0);
        step();
        step();
        #1;
        chk("t4_g3err", 32'(bus.d_err_o), 32'h0);
        step();
        bus.s_ack_i = 1'b1;
        #1;
        chk("t4_ack", 32'(bus.d_ack_o), 32'h1);
        chk("t4_err", 32'(bus.d_err_o), 32'h0);
        step();
        idle_inputs();
        #1;
        chk("t4_to", 32'(bus.timeout_o), 32'h0);
        chk("t4_idle", 32'(bus.gnt_o), 32'h0);

        // DBUS write never acked: error in the 4th grant cycle
        do_reset();
        d_req(1'b1);
        step();
        #1;
        chk("t3_g1", 32'(bus.gnt_o), 32'h2);
        chk("t3_e1", 32'(bus.d_err_o), 32'h0);
        step();
        step();
        #1;
        chk("t3_e3", 32'(bus.d_err_o), 32'h0);
        chk("t3_to3", 32'(bus.timeout_o), 32'h0);
        step();
        #1;
        chk("t3_e4", 32'(bus.d_err_o), 32'h1);
        chk("t3_g4", 32'(bus.gnt_o), 32'h2);
        chk("t3_ie", 32'(bus.i_err_o), 32'h0);
        step();
        d_req(1'b0);
        bus.i_adr_i = 32'h0000_0300;
        bus.i_cyc_i = 1'b1;
        bus.i_stb_i = 1'b1;
        #1;
        chk("t3_idle", 32'(bus.gnt_o), 32'h0);
        chk("t3_to", 32'(bus.timeout_o), 32'h1);
        step();
        bus.s_ack_i = 1'b1;
        #1;
        chk("t3_ig", 32'(bus.gnt_o), 32'h1);
        chk("t3_iack", 32'(bus.i_ack_o), 32'h1);
        chk("t3_ierr", 32'(bus.i_err_o), 32'h0);
        step();
        bus.s_ack_i = 1'b0;
        bus.i_cyc_i = 1'b0;
        bus.i_stb_i = 1'b0;
        #1;
        chk("t3_sticky", 32'(bus.timeout_o), 32'h1);

        // IBUS abandons mid-wait while DBUS is pending
        bus.i_cyc_i = 1'b1;
        bus.i_stb_i = 1'b1;
        step();
        d_req(1'b1);
        #1;
        chk("t5_gi", 32'(bus.gnt_o), 32'h1);
        step();
        bus.i_cyc_i = 1'b0;
        bus.i_stb_i = 1'b0;
        #1;
        chk("t5_cyc0", 32'(bus.s_cyc_o), 32'h0);
        chk("t5_gi2", 32'(bus.gnt_o), 32'h1);
        step();
        #1;
        chk("t5_idle", 32'(bus.gnt_o), 32'h0);
        step();
        #1;
        chk("t5_gd", 32'(bus.gnt_o), 32'h2);
        chk("t5_dcyc", 32'(bus.s_cyc_o), 32'h1);

        // Reset during GNT_D
        rst = 1'b1;
        step();
        bus.s_ack_i = 1'b1;
        #1;
        chk("t6_gnt", 32'(bus.gnt_o), 32'h0);
        chk("t6_cyc", 32'(bus.s_cyc_o), 32'h0);
        chk("t6_stb", 32'(bus.s_stb_o), 32'h0);
        chk("t6_adr", bus.s_adr_o, 32'h0);
        chk("t6_dat", bus.s_dat_o, 32'h0);
        chk("t6_to", 32'(bus.timeout_o), 32'h0);
        chk("t6_dack", 32'(bus.d_ack_o), 32'h0);
        chk("t6_iack", 32'(bus.i_ack_o), 32'h0);
        chk("t6_derr", 32'(bus.d_err_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_ibus_dbus_arbiter.md
# wb_ibus_dbus_arbiter

Two-master, one-slave Wishbone classic arbiter that lets the core's instruction port (read-only) and data port share a single memory/Controller bus when a second memory port is not available. It sits between the core's IBUS/DBUS master interfaces and the single `core_*` slave port. It uses round-robin grant, a one-cycle turnaround between transactions, and a per-transaction ack timeout that returns a bus error to the owning master.

## Interface
- `TIMEOUT_CYCLES`, 1024: number of cycles a granted transaction may wait for `s_ack_i` before it is aborted; 0 disables the timeout.
- `wb_clk_i`  in  1  single clock; all state changes on its rising edge.
- `wb_rst_i`  in  1  reset; synchronous and active-high.
- `i_adr_i`  in  32  IBUS address.
- `i_cyc_i`, `i_stb_i`  in  1 each  IBUS cycle and strobe.
- `i_dat_o`  out  32  IBUS read data (= `s_dat_i`).
- `i_ack_o`, `i_err_o`  out  1 each  IBUS ack and error.
- `d_adr_i`  in  32  DBUS address.
- `d_dat_i`  in  32  DBUS write data.
- `d_we_i`  in  1  DBUS write enable.
- `d_sel_i`  in  4  DBUS byte selects.
- `d_cyc_i`, `d_stb_i`  in  1 each  DBUS cycle and strobe.
- `d_dat_o`  out  32  DBUS read data (= `s_dat_i`).
- `d_ack_o`, `d_err_o`  out  1 each  DBUS ack and error.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave cycle, strobe and write enable.
- `s_sel_o`  out  4  slave byte selects.
- `s_adr_o`  out  32  slave address.
- `s_dat_o`  out  32  slave write data.
- `s_dat_i`  in  32  slave read data.
- `s_ack_i`  in  1  slave ack.
- `gnt_o`  out  2  current owner: 00 none, 01 IBUS, 10 DBUS.
- `timeout_o`  out  1  sticky flag, set by any timeout and cleared only by reset.

## Operation
- FSM states: IDLE, GNT_I, GNT_D.
- Request definitions: `req_i = i_cyc_i & i_stb_i` and `req_d = d_cyc_i & d_stb_i`.
- IDLE transitions:
  - only `req_i`: go to GNT_I.
  - only `req_d`: go to GNT_D.
  - both: grant the master that was not served last (`last_d` register; 1 = DBUS served last).
  - neither: stay in IDLE.
- Entering GNT_I clears `last_d`; entering GNT_D sets `last_d`.
- GNT_x exits to IDLE when any of these occurs:
  - owner asserts ack (`s_ack_i`);
  - owner drops `cyc` (abandon);
  - timeout fires.
- There is no direct GNT_I to GNT_D hop: IDLE is always visited for one cycle between transactions.
- Slave-side muxing (combinational from state):
  - GNT_I: `s_cyc_o = i_cyc_i`, `s_stb_o = i_stb_i`, `s_adr_o = i_adr_i`, `s_we_o = 0`, `s_sel_o = 4'b1111`, `s_dat_o = 0`.
  - GNT_D: all slave outputs are taken from the corresponding `d_*` inputs.
  - IDLE: all slave outputs are 0.
- Ack/err routing:
  - `i_ack_o = s_ack_i & GNT_I`; `d_ack_o = s_ack_i & GNT_D`.
  - `s_ack_i` in IDLE is ignored and not forwarded.
  - Read data is broadcast to both masters; only the acked master samples it.
- Timeout:
  - `wait_cnt` is cleared in IDLE and increments each GNT cycle without `s_ack_i`.
  - When `TIMEOUT_CYCLES != 0`, `wait_cnt == TIMEOUT_CYCLES-1` and no `s_ack_i`: the owner's `*_err_o` is 1 for that cycle, the FSM goes to IDLE, and `timeout_o` is set.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.
- Simultaneous ack and timeout: ack wins, no err, `timeout_o` unchanged.
- Owner drops `cyc` in the same cycle as `s_ack_i`: ack is still forwarded; the FSM goes to IDLE.
- Reset mid-transaction: the next cycle is IDLE and all slave outputs are 0. The aborted master receives no ack or err.

## Timing
- Reset values: state IDLE, `last_d = 1` (first tie goes to IBUS), `wait_cnt = 0`, `timeout_o = 0`, `gnt_o = 00`.
  - All `s_*` outputs, `*_ack_o` and `*_err_o` are 0.
  - `i_dat_o` and `d_dat_o` follow `s_dat_i` (not registered).
- Arbitration latency: a request visible at edge n is granted in state at edge n+1; `s_stb_o` is high during cycle n+1.
- Ack path is combinational, with zero added latency.
- After ack at cycle k: IDLE at k+1; the earliest new grant is at k+2. Back-to-back throughput is therefore at most one transaction per 3 cycles for a 1-cycle slave.
- Timeout with `TIMEOUT_CYCLES = T`: err appears in the T-th GNT cycle after the grant.

## Test plan
- Single IBUS read, slave acks 1 cycle after `s_stb_o` with `s_dat_i = 32'hDEADBEEF` -> `i_ack_o` pulses once, `i_dat_o = DEADBEEF`, `s_we_o = 0`, `s_sel_o = 1111`, `gnt_o` sequence 00, 01, 00.
- IBUS and DBUS request in the same cycle right after reset, both held -> IBUS granted first, then DBUS (write, `d_sel_i = 0011`, `d_dat_i = 32'h12345678` seen on `s_*`), then IBUS again; grants strictly alternate.
- DBUS write, slave never acks, `TIMEOUT_CYCLES = 4` -> `d_err_o` high on the 4th grant cycle, `timeout_o` stays 1, FSM back to IDLE; a following IBUS request is served normally.
- `s_ack_i` on the same cycle as the timeout-expiry cycle -> `d_ack_o = 1`, `d_err_o = 0`, `timeout_o = 0`.
- IBUS owner drops `i_cyc_i` mid-wait, DBUS pending -> `s_cyc_o` falls the same cycle, IDLE next, DBUS granted the cycle after.
- `wb_rst_i` asserted during GNT_D -> next cycle all `s_*`, `gnt_o` and `timeout_o` are 0; a stray `s_ack_i` in IDLE yields no `*_ack_o`.
